key_debounce_bank: RTL and testbench
====================================

KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent key channels (1..32).
REQ-002 SHALL have parameter DEB_CYCLES, default 120000: consecutive stable samples required to accept a level change (>=1).
REQ-003 SHALL have parameter LONG_CYCLES, default 6000000: hold time in cycles from press acceptance to long-press pulse (>DEB_CYCLES).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 1200000: auto-repeat period in cycles after long-press (>=1).
REQ-005 SHALL have parameter REPEAT_EN, default 1: 1 = auto-repeat enabled, 0 = o_rep tied low.
REQ-006 i_clk  input  1  single clock for all logic.
REQ-007 i_rst_n  input  1  reset; synchronous and active-low.
REQ-008 i_in  input  N_CH  raw asynchronous key levels, active-low (0 = pressed).
REQ-009 o_level  output  N_CH  debounced level per channel (0 = pressed).
REQ-010 o_neg  output  N_CH  one-cycle pulse on accepted press (1->0).
REQ-011 o_pos  output  N_CH  one-cycle pulse on accepted release (0->1).
REQ-012 o_long  output  N_CH  one-cycle pulse when press held LONG_CYCLES.
REQ-013 o_rep  output  N_CH  one-cycle auto-repeat pulse while held past long-press.

Function
REQ-014 Each i_in bit SHALL pass a 2-flop synchronizer; flops reset to 1.
REQ-015 Per channel, mismatch counter SHALL increment each cycle synced value != o_level, and clear to 0 on any cycle they match (glitch rejection).
REQ-016 On the cycle the DEB_CYCLES-th consecutive mismatching sample is seen, o_level SHALL take the synced value and the counter SHALL clear.
REQ-017 Latency: i_in change before edge k (held stable) SHALL appear on o_level after edge k+1+DEB_CYCLES.
REQ-018 Input pulse/glitch shorter than DEB_CYCLES cycles at synchronizer output SHALL produce no o_level change and no pulses.
REQ-019 o_neg/o_pos SHALL be registered, high exactly one cycle, in the first cycle o_level shows the new value.
REQ-020 Hold counter SHALL clear on the o_neg cycle, increment each cycle while o_level=0, saturate at its max (no wrap), and clear when o_level=1.
REQ-021 o_long SHALL pulse exactly LONG_CYCLES cycles after the o_neg cycle, once per press, only if o_level stays 0 throughout.
REQ-022 With REPEAT_EN=1, o_rep SHALL pulse at LONG_CYCLES + k*REPEAT_CYCLES cycles after o_neg, k=1,2,..., for as long as held; repeat timer SHALL restart each pulse and never saturate-stop.
REQ-023 Release (o_pos) SHALL immediately cancel pending o_long/o_rep; none SHALL fire in the o_pos cycle or later for that press.
REQ-024 o_pos and o_long/o_rep SHALL never be high in the same cycle on one channel; o_long and o_rep SHALL never coincide.
REQ-025 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL all pulse in the same cycle.
REQ-026 Per-channel state: RELEASED, PRESS_WAIT (pressed, < LONG), LONG_HELD; RELEASED->PRESS_WAIT on o_neg, PRESS_WAIT->LONG_HELD on o_long, any->RELEASED on o_pos.

Reset
REQ-027 With i_rst_n=0 at an edge: synchronizers=1, o_level=all 1, all counters 0, state RELEASED, o_neg/o_pos/o_long/o_rep=0.
REQ-028 Reset mid-press SHALL discard the press with no pulses; key still held after release SHALL produce o_neg after DEB_CYCLES+2 cycles, as a fresh press.
REQ-029 No pulse output SHALL assert in the first cycle after reset deassertion.

Verification (N_CH=3, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1)
REQ-030 i_in[0] 1->0 before edge 10, held -> o_level[0]=0 and o_neg[0]=1 after edge 15 only; o_long[0] after edge 35; o_rep[0] after edges 43, 51, 59.
REQ-031 i_in[1] low for 3 cycles then high -> o_level[1] stays 1, no pulses on channel 1.
REQ-032 press ch2 held 12 cycles past o_neg then released -> o_pos[2] once, no o_long[2], no o_rep[2].
REQ-033 ch0 and ch2 pressed same cycle -> o_neg=3'b101 in a single cycle; releases same cycle -> o_pos=3'b101.
REQ-034 i_rst_n=0 for 2 cycles 10 cycles after o_neg[0] with key still held -> o_level=3'b111, no o_long; new o_neg[0] 6 cycles after reset release.
REQ-035 Bounce 0/1 alternating every 2 cycles for 20 cycles, then stable 0 -> exactly one o_neg, 6 cycles after final stable edge.

Source files
------------

// File: rtl/key_debounce_bank.sv
// Multi-channel key debouncer with press/release edge pulses, long-press
// detection and optional auto-repeat. Keys are active-low; reset is synchronous.
module key_debounce_bank #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_neg,
  output logic [N_CH-1:0] o_pos,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_rep
);

  localparam int MW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [MW-1:0] MIS_LAST  = MW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_WAIT = 2'd1,
    LONG_HELD  = 2'd2
  } state_e;

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  // Two-flop synchronizer; idles at the released level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e          state_q, state_d;
    logic [MW-1:0]   mis_q, mis_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [RW-1:0]   rpt_q, rpt_d;
    logic            level_q, level_d;
    logic            neg_q, neg_d;
    logic            pos_q, pos_d;
    logic            long_q, long_d;
    logic            rep_q, rep_d;
    logic            accept_s;

    // Debounce, hold timing and press-state next-state logic.
    always_comb begin
      mis_d    = '0;
      level_d  = level_q;
      accept_s = 1'b0;
      if (sync2_q[g] != level_q) begin
        if (mis_q == MIS_LAST) begin
          accept_s = 1'b1;
          level_d  = sync2_q[g];
        end else begin
          mis_d = mis_q + 1'b1;
        end
      end else begin
        mis_d = '0;
      end

      neg_d = accept_s & ~sync2_q[g];
      pos_d = accept_s &  sync2_q[g];

      // Saturating hold timer restarted by every accepted press.
      hold_d = '0;
      if (!level_q && !neg_d && !pos_d) begin
        hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
      end else begin
        hold_d = '0;
      end

      state_d = state_q;
      rpt_d   = rpt_q;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
        RELEASED: begin
          rpt_d = '0;
          if (neg_d) begin
            state_d = PRESS_WAIT;
          end else begin
            state_d = RELEASED;
          end
        end
        PRESS_WAIT: begin
          if (pos_d) begin
            state_d = RELEASED;
          end else if (hold_q == HOLD_LAST) begin
            long_d  = 1'b1;
            rpt_d   = '0;
            state_d = LONG_HELD;
          end else begin
            state_d = PRESS_WAIT;
          end
        end
        LONG_HELD: begin
          if (pos_d) begin
            state_d = RELEASED;
          end else if (rpt_q == REP_LAST) begin
            rep_d = REPEAT_EN;
            rpt_d = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          rpt_d   = '0;
        end
      endcase
    end

    // Per-channel state and registered pulse outputs.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        state_q <= RELEASED;
        mis_q   <= '0;
        hold_q  <= '0;
        rpt_q   <= '0;
        level_q <= 1'b1;
        neg_q   <= 1'b0;
        pos_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        mis_q   <= mis_d;
        hold_q  <= hold_d;
        rpt_q   <= rpt_d;
        level_q <= level_d;
        neg_q   <= neg_d;
        pos_q   <= pos_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
      end
    end

    assign o_level[g] = level_q;
    assign o_neg[g]   = neg_q;
    assign o_pos[g]   = pos_q;
    assign o_long[g]  = long_q;
    assign o_rep[g]   = rep_q;
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank: expected pulses are queued per clock
// edge as stimulus is applied and compared cycle by cycle at the falling edge.
module tb_key_debounce_bank;
  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_s = 3'b111;
  logic [N-1:0] level, neg, pos, lng, rep;

  int           cyc = 0;
  logic         edge_rst = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           obs_pulses = 0;
  logic [N-1:0] exp_lvl = 3'b111;

  typedef struct {
    int         cyc;
    logic [2:0] neg;
    logic [2:0] pos;
    logic [2:0] lng;
    logic [2:0] rep;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [2:0] mask;
    int         len;
    int         exp_pulses;
  } vec_t;
  vec_t vecs[7];

  key_debounce_bank #(
    .N_CH(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_s),
    .o_level(level), .o_neg(neg), .o_pos(pos), .o_long(lng), .o_rep(rep)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    edge_rst <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // kind: 0 neg, 1 pos, 2 long, 3 rep
  function automatic void push(input int c, input int kind, input logic [2:0] m);
    ev_t e;
    int  idx;
    e.cyc = c; e.neg = 3'b000; e.pos = 3'b000; e.lng = 3'b000; e.rep = 3'b000;
    case (kind)
      0: e.neg = m;
      1: e.pos = m;
      2: e.lng = m;
      default: e.rep = m;
    endcase
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == c) begin
        sb[i].neg |= e.neg; sb[i].pos |= e.pos;
        sb[i].lng |= e.lng; sb[i].rep |= e.rep;
        return;
      end
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  // Clean press: low before edge k, held for len edges, then released.
  function automatic void expect_press(input int k, input int len, input logic [2:0] m);
    int t_neg, t_pos, t;
    if (len >= DEB) begin
      t_neg = k + 1 + DEB;
      t_pos = k + len + 1 + DEB;
      push(t_neg, 0, m);
      push(t_pos, 1, m);
      t = t_neg + LONG;
      if (t < t_pos) push(t, 2, m);
      t = t + REP;
      while (t < t_pos) begin
        push(t, 3, m);
        t = t + REP;
      end
    end
  endfunction

  always @(negedge clk) begin : monitor
    ev_t        e;
    logic [2:0] nxt;
    if (cyc > 0) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
      end else begin
        e.cyc = cyc; e.neg = 3'b000; e.pos = 3'b000; e.lng = 3'b000; e.rep = 3'b000;
      end
      check("pulses{neg,pos,long,rep}", {neg, pos, lng, rep}, {e.neg, e.pos, e.lng, e.rep});
      nxt = (!edge_rst) ? 3'b111 : ((exp_lvl & ~e.neg) | e.pos);
      check("level", level, nxt);
      exp_lvl    <= nxt;
      obs_pulses <= obs_pulses + $countones({neg, pos, lng, rep});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  initial begin
    int k, f, base;
    vecs[0] = '{3'b010,  3, 0};
    vecs[1] = '{3'b100, 12, 2};
    vecs[2] = '{3'b101, 10, 4};
    vecs[3] = '{3'b001, 60, 7};
    vecs[4] = '{3'b001,  4, 2};
    vecs[5] = '{3'b010, 25, 3};
    vecs[6] = '{3'b010, 20, 2};

    rst_n = 1'b0;
    in_s  = 3'b111;
    step(3);
    rst_n = 1'b1;

    // Absolute-edge press on channel 0.
    wait_until(9);
    in_s[0] = 1'b0;
    push(15, 0, 3'b001);
    push(35, 2, 3'b001);
    push(43, 3, 3'b001);
    push(51, 3, 3'b001);
    push(59, 3, 3'b001);
    wait_until(61);
    in_s[0] = 1'b1;
    push(67, 1, 3'b001);
    wait_until(80);

    for (int i = 0; i < 7; i++) begin
      k    = cyc + 1;
      base = obs_pulses;
      in_s = in_s & ~vecs[i].mask;
      expect_press(k, vecs[i].len, vecs[i].mask);
      step(vecs[i].len);
      in_s = in_s | vecs[i].mask;
      step(DEB + 12);
      check("vec_pulse_count", obs_pulses - base, vecs[i].exp_pulses);
    end

    // Reset in the middle of a held press.
    base = obs_pulses;
    k = cyc + 1;
    in_s[0] = 1'b0;
    push(k + 5, 0, 3'b001);
    wait_until(k + 14);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    push(k + 22, 0, 3'b001);
    push(k + 42, 2, 3'b001);
    wait_until(k + 44);
    in_s[0] = 1'b1;
    push(k + 50, 1, 3'b001);
    step(15);
    check("reset_pulse_count", obs_pulses - base, 4);

    // Bouncing contact settling low.
    base = obs_pulses;
    for (int i = 0; i < 20; i++) begin
      in_s[0] = ((i / 2) % 2) ? 1'b1 : 1'b0;
      step(1);
    end
    in_s[0] = 1'b0;
    f = cyc + 1;
    push(f + 5, 0, 3'b001);
    wait_until(f + 9);
    in_s[0] = 1'b1;
    push(f + 15, 1, 3'b001);
    step(15);
    check("bounce_pulse_count", obs_pulses - base, 2);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
